// File: rtl/ifetch_prefetch_unit.sv
// Instruction-fetch front end: owns the PC, prefetches into a small FIFO, flushes on redirect.
// Optional performance counters are enabled with the IFETCH_PERF_CNT_EN macro.
module ifetch_prefetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW+1:0] DEPTH_W = FIFO_DEPTH[PW+1:0];

   logic [31:0]   fetch_pc;
   logic          inflight;
   logic [31:0]   inflight_pc;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic [31:0]   mem_inst [FIFO_DEPTH];
   logic [31:0]   mem_pc   [FIFO_DEPTH];

   logic          pop;
   logic          push;
   logic [PW+1:0] occ;

   // Valid/ready: an instruction moves to decode on any rising edge where inst_valid
   // and inst_ready are both high; a redirect in the same cycle cancels the transfer.
   always_comb begin
      pop  = 1'b0;
      push = 1'b0;
      occ  = '0;
      pop  = (count != '0) && inst_ready && !redirect_valid;
      push = inflight && !redirect_valid;
      // Credits: buffered entries plus the in-flight fetch, minus the slot freed this cycle.
      occ  = {1'b0, count} + {{(PW+1){1'b0}}, inflight} - {{(PW+1){1'b0}}, pop};
   end

   assign imem_en    = rst && !redirect_valid && (occ < DEPTH_W);
   assign imem_addr  = fetch_pc;
   assign inst_valid = (count != '0);
   assign inst       = mem_inst[rd_ptr];
   assign inst_pc    = mem_pc[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_inst[i] <= '0;
            mem_pc[i]   <= '0;
         end
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (imem_en) begin
            fetch_pc    <= fetch_pc + 32'd4;
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
         end else begin
            inflight <= 1'b0;
         end
         if (push) begin
            mem_inst[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= inflight_pc;
            wr_ptr           <= wr_ptr + {{(PW-1){1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr <= rd_ptr + {{(PW-1){1'b0}}, 1'b1};
         end
         case ({push, pop})
            2'b10:   count <= count + {{PW{1'b0}}, 1'b1};
            2'b01:   count <= count - {{PW{1'b0}}, 1'b1};
            default: count <= count;
         endcase
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   // A flush only counts when something was actually thrown away.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetch_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (redirect_valid && ((count != '0) || inflight))
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/ifetch_prefetch_unit.md
Name: ifetch_prefetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the decoder/controller.
- Owns the PC and issues sequential word fetches to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts a branch redirect from the execute stage, which flushes all buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- FIFO_DEPTH, 2, number of prefetch buffer entries (power of two, 2..8).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (low = reset).
- imem_en  output  1  fetch request this cycle.
- imem_addr  output  32  byte address of the fetch; bits [1:0] are always 0.
- imem_rdata  input  32  instruction word; valid the cycle after imem_en was high.
- redirect_valid  input  1  branch/jump taken; overrides the PC.
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and forced to 0.
- inst_valid  output  1  FIFO head holds a valid instruction.
- inst  output  32  instruction at the FIFO head.
- inst_pc  output  32  PC of the FIFO head.
- inst_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Reset (rst low, asynchronous):
  - fetch_pc = RESET_PC; FIFO empty; no fetch in flight.
  - Outputs: imem_en=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- State:
  - fetch_pc (32b).
  - inflight flag plus inflight_pc.
  - FIFO with read/write pointers and count of 0..FIFO_DEPTH.
- Pop: inst_valid && inst_ready. The head advances at the clock edge.
- Issue rule: imem_en = !redirect_valid && (count + inflight - pop) < FIFO_DEPTH.
  - This is a credit scheme: every issued fetch has a reserved slot, so the FIFO can never overflow.
  - inst_ready → imem_en is a permitted combinational path.
- On issue: imem_addr = fetch_pc; fetch_pc <= fetch_pc + 4; inflight <= 1; inflight_pc <= fetch_pc.
- No issue: inflight <= 0.
- Response: in the cycle after an issue, imem_rdata is pushed as {inflight_pc, imem_rdata} unless a redirect occurs that cycle.
- Latency:
  - A fetch issued in cycle N has its data in cycle N+1 and appears at the head (inst_valid) in cycle N+2 when the FIFO was empty.
  - First imem_en is the first cycle after rst deasserts.
- Throughput: 1 instruction/cycle sustained while inst_ready is held high.
- Simultaneous push and pop: both occur; count is unchanged; head order is preserved.
- FIFO full (count == FIFO_DEPTH): inst_valid=1; no issue unless a pop occurs that cycle.
- FIFO empty: inst_valid=0; inst and inst_pc hold their last values (don't-care).
- Redirect (redirect_valid=1), with priority over all other events:
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - FIFO cleared, so inst_valid=0 the next cycle.
  - In-flight response discarded; no push.
  - No issue that cycle; the pop is ignored.
  - First fetch of the target is issued the next cycle, and the target reaches the head 2 cycles after that.
- Back-to-back redirects: the last one wins; each flushes.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- Reset mid-operation: all state is cleared immediately; any pending response is dropped.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- When defined, adds output perf_fetch_cnt[31:0] and output perf_flush_cnt[31:0]:
  - perf_fetch_cnt increments on each pop.
  - perf_flush_cnt increments on each redirect cycle that discards at least one buffered or in-flight instruction.
  - Both reset to 0 and wrap at 2^32.
- When undefined, neither port nor its logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0, inst_ready=1, imem returning addr^32'hA5A5_0000 → imem_addr 0,4,8,... one per cycle; inst_valid first high 2 cycles after reset release; inst/inst_pc pairs match; 1 inst/cycle.
- Backpressure: inst_ready=0 for 6 cycles → at most 2 entries buffered; imem_en drops after reaching credit limit; on release, PCs 0,4 popped in order with no loss or duplication.
- Redirect to 32'h0000_0103 with FIFO full and a fetch in flight → next cycle inst_valid=0 and imem_addr=32'h100; next inst_pc seen is 32'h100; no stale PC appears.
- Redirect held 3 consecutive cycles with targets 0x40, 0x80, 0xC0 → only 0xC0 is fetched; first fetch the cycle after redirect drops.
- Wrap: redirect to 32'hFFFF_FFF8 → inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst mid-stream with FIFO non-empty → outputs are at reset values immediately (asynchronously); after release, fetch restarts at RESET_PC; with IFETCH_PERF_CNT_EN, counters read 0.
